noise_gate: RTL and testbench
=============================

Name: noise_gate

Overview:
- Stereo downward expander / noise gate: the complement of the peak compressor in the effects chain. It attenuates the signal when it falls *below* a threshold, rather than limiting peaks above it.
- A linked-stereo attack/hold/release state machine drives one shared gain, which is applied to both channels.
- Sits in the per-sample audio path between the codec receive interface and the downstream effects.
- Processes one stereo sample per in_valid strobe.

Parameters:
- THRESHOLD, 32'h0100_0000: open threshold; a sample opens the gate when its magnitude is ≥ this value.
- HOLD_SAMPLES, 480: number of consecutive below-threshold samples required before release begins. Legal range 1..65535.
- ATTACK_STEP, 32: gain increment per valid sample while in ATTACK. Range 1..256.
- RELEASE_STEP, 1: gain decrement per valid sample while in RELEASE. Range 1..256.
- GAIN_FLOOR, 0: closed-gate gain. Range 0..255.
- HYSTERESIS, 32'h0080_0000: close threshold becomes THRESHOLD-HYSTERESIS. Used only with NOISE_GATE_HYST_EN.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  strobe marking one new stereo sample
- inleft  in  32  left sample, signed two's complement
- inright  in  32  right sample, signed two's complement
- out_valid  out  1  strobe marking a processed sample
- outleft  out  32  gated left sample, signed
- outright  out  32  gated right sample, signed
- gain  out  9  current gain, unsigned Q1.8; 256 = unity
- gate_open  out  1  high in every state except CLOSED

Behaviour:
- Reset (asynchronous, active-high; applies mid-operation as well):
  - state = CLOSED, gain = GAIN_FLOOR, hold counter = 0.
  - out_valid = 0, outleft = outright = 0, gate_open = 0.
- in_valid low: no state, gain, counter or output change; out_valid = 0.
- Latency: exactly 1 clock. out_valid is in_valid delayed one cycle. Outputs hold their value between strobes.
- Magnitude: |x|. The value -2^31 saturates to 2^31-1.
- Per-sample signals:
  - hot = |inleft| ≥ THRESHOLD OR |inright| ≥ THRESHOLD (either channel suffices).
  - quiet = both magnitudes < close threshold. Without hysteresis the close threshold is THRESHOLD, so quiet = !hot.
- Gain application:
  - out = (in * gain_before_update) >>> 8.
  - Signed 32x9 multiply into a 41-bit product, arithmetic shift right (truncates toward -inf), take the low 32 bits.
  - gain = 256 passes the input bit-exact.
  - The state/gain update for a sample takes effect from the next sample onward.
- FSM (evaluated once per valid sample):
  - CLOSED: gain = GAIN_FLOOR; on hot → ATTACK.
  - ATTACK: gain = min(gain+ATTACK_STEP, 256).
    - If quiet and gain has not yet reached 256: → RELEASE.
    - Otherwise, when the new gain reaches 256: → OPEN.
  - OPEN: gain = 256; on quiet → HOLD with counter = HOLD_SAMPLES-1.
  - HOLD: gain = 256.
    - hot → OPEN (counter cleared).
    - quiet with counter = 0 → RELEASE.
    - Otherwise counter decrements.
  - RELEASE: gain = max(gain-RELEASE_STEP, GAIN_FLOOR), saturating with no wrap.
    - hot → ATTACK, continuing from the current gain.
    - When gain reaches GAIN_FLOOR → CLOSED.
- Simultaneous hot and quiet cannot occur. Under hysteresis, a sample between the two thresholds is neither hot nor quiet: the state is held, except that ATTACK/RELEASE gain ramps continue.
- Gain arithmetic uses a 10-bit intermediate so no overflow is possible.

Optional Feature:
- Macro NOISE_GATE_HYST_EN.
  - Defined: close threshold = THRESHOLD-HYSTERESIS (clamped at 0), giving a dead band that prevents chatter.
  - Undefined: the HYSTERESIS parameter is ignored, and the open and close thresholds are equal.

Decomposition:
- Package noise_gate_pkg:
  - gate_state_t enum {CLOSED, ATTACK, OPEN, HOLD, RELEASE}.
  - GAIN_W = 9, GAIN_UNITY = 9'd256.
  - SAMPLE_W = 32, sample_t.
  - Magnitude function abs_sat.
- Sub-module audio_gain_apply: combinational signed multiply-and-shift, instantiated once per channel.

Test Plan:
- Reset check: assert reset mid-ATTACK → next edge-independent: state CLOSED, gain = 0, outputs 0, out_valid 0.
- Attack ramp (ATTACK_STEP=32, FLOOR=0): 10 valid samples with inleft=32'h0200_0000, inright=0.
  - First outleft = 0; k-th output = 32'h0200_0000*32*(k-1)>>8.
  - gain reaches 256 after the 8th sample, gate → OPEN, later outputs are bit-exact.
- Hold/release (HOLD_SAMPLES=4, RELEASE_STEP=64):
  - From OPEN, feed samples of 32'h0000_0010.
  - 4 samples at unity in HOLD, then gain 192, 128, 64, 0 → CLOSED.
- Re-trigger: in HOLD after 2 quiet samples, inject inright=32'hFE00_0000 (negative, hot) → back to OPEN, counter restarts on the next quiet run.
- Edge values: inleft=32'h8000_0000 → treated as hot; outleft = (-2^31*gain)>>>8 with correct sign. in_valid gaps of 3 cycles change nothing.
- Hysteresis (NOISE_GATE_HYST_EN, THRESHOLD=32'h0100_0000, HYST=32'h0080_0000): from OPEN, sample 32'h00C0_0000 keeps OPEN; 32'h0070_0000 → HOLD. Without the macro, 32'h00C0_0000 → HOLD.

Source files
------------

// File: rtl/noise_gate_pkg.sv
// noise_gate_pkg: shared types, constants and helpers for the noise gate.
//   gate_state_t : linked-stereo gate state (CLOSED, ATTACK, OPEN, HOLD, RELEASE)
//   GAIN_W       : width of the unsigned Q1.8 gain (256 = unity)
//   GAIN_UNITY   : unity gain
//   SAMPLE_W     : audio sample width
//   sample_t     : signed two's complement audio sample
//   abs_sat()    : magnitude with -2^31 saturating to 2^31-1
package noise_gate_pkg;

    localparam int unsigned GAIN_W = 9;
    localparam logic [GAIN_W-1:0] GAIN_UNITY = 9'd256;

    localparam int unsigned SAMPLE_W = 32;
    typedef logic signed [SAMPLE_W-1:0] sample_t;

    typedef enum logic [2:0] {
        CLOSED,
        ATTACK,
        OPEN,
        HOLD,
        RELEASE
    } gate_state_t;

    // The most negative sample has no positive counterpart; clamp it to the
    // largest positive value so it still compares as a very loud sample.
    function automatic logic [SAMPLE_W-1:0] abs_sat(input sample_t x);
        logic [SAMPLE_W-1:0] neg;
        neg = -x;
        if (!x[SAMPLE_W-1]) begin
            abs_sat = x;
        end else if (neg[SAMPLE_W-1]) begin
            abs_sat = {1'b0, {(SAMPLE_W-1){1'b1}}};
        end else begin
            abs_sat = neg;
        end
    endfunction

endpackage

// File: rtl/noise_gate_gain_apply.sv
// audio_gain_apply: combinational gain stage for one audio channel.
//   i_sample : signed input sample
//   i_gain   : unsigned Q1.8 gain, 256 = unity
//   o_sample : (i_sample * i_gain) >>> 8, low SAMPLE_W bits
// Unity gain passes the sample bit-exact; the shift truncates toward -inf.
module audio_gain_apply
    import noise_gate_pkg::*;
(
    input  sample_t           i_sample,
    input  logic [GAIN_W-1:0] i_gain,
    output sample_t           o_sample
);

    localparam int unsigned PROD_W = SAMPLE_W + GAIN_W;

    logic signed [PROD_W-1:0] w_product;

    // Gain is zero-extended so it is treated as a positive signed operand.
    assign w_product = $signed(PROD_W'(i_sample)) * $signed(PROD_W'({1'b0, i_gain}));
    assign o_sample  = sample_t'(w_product >>> 8);

endmodule

// File: rtl/noise_gate.sv
// noise_gate: stereo downward expander / noise gate with linked-stereo
// attack/hold/release control driving one gain shared by both channels.
//
// Ports:
//   clock     : system clock
//   reset     : asynchronous, active-high reset
//   in_valid  : strobe marking one new stereo sample
//   inleft    : left sample, signed
//   inright   : right sample, signed
//   out_valid : in_valid delayed by one clock
//   outleft   : gated left sample, signed (held between strobes)
//   outright  : gated right sample, signed (held between strobes)
//   gain      : current gain, unsigned Q1.8, 256 = unity
//   gate_open : high in every state except CLOSED
//
// Build option:
//   NOISE_GATE_HYST_EN : when defined, the close threshold is
//   THRESHOLD-HYSTERESIS (clamped at 0); samples in the dead band between the
//   two thresholds are neither hot nor quiet. Undefined: both thresholds equal.
module noise_gate
    import noise_gate_pkg::*;
#(
    parameter logic [31:0] THRESHOLD    = 32'h0100_0000,
    parameter int unsigned HOLD_SAMPLES = 480,
    parameter int unsigned ATTACK_STEP  = 32,
    parameter int unsigned RELEASE_STEP = 1,
    parameter int unsigned GAIN_FLOOR   = 0,
    parameter logic [31:0] HYSTERESIS   = 32'h0080_0000
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                in_valid,
    input  logic [31:0]         inleft,
    input  logic [31:0]         inright,
    output logic                out_valid,
    output logic [31:0]         outleft,
    output logic [31:0]         outright,
    output logic [GAIN_W-1:0]   gain,
    output logic                gate_open
);

    // Gain arithmetic runs one bit wider than the gain so sums cannot wrap.
    localparam logic [GAIN_W:0] ATK_STEP  = (GAIN_W + 1)'(ATTACK_STEP);
    localparam logic [GAIN_W:0] REL_STEP  = (GAIN_W + 1)'(RELEASE_STEP);
    localparam logic [GAIN_W:0] FLOOR     = (GAIN_W + 1)'(GAIN_FLOOR);
    localparam logic [GAIN_W:0] UNITY     = {1'b0, GAIN_UNITY};
    localparam logic [15:0]     HOLD_INIT = 16'(HOLD_SAMPLES - 1);

`ifdef NOISE_GATE_HYST_EN
    localparam logic [31:0] CLOSE_THR = (THRESHOLD > HYSTERESIS) ?
                                        (THRESHOLD - HYSTERESIS) : 32'd0;
`else
    localparam logic [31:0] CLOSE_THR = THRESHOLD;
    logic w_unused_hyst;
    assign w_unused_hyst = ^HYSTERESIS;
`endif

    gate_state_t       r_state;
    gate_state_t       w_state_d;
    logic [GAIN_W-1:0] r_gain;
    logic [GAIN_W-1:0] w_gain_d;
    logic [15:0]       r_hold_cnt;
    logic [15:0]       w_hold_cnt_d;
    logic              r_out_valid;
    sample_t           r_outleft;
    sample_t           r_outright;

    logic [31:0]       w_mag_left;
    logic [31:0]       w_mag_right;
    logic              w_hot;
    logic              w_quiet;
    logic [GAIN_W:0]   w_sum_up;
    logic [GAIN_W:0]   w_gain_up;
    logic [GAIN_W:0]   w_gain_dn;
    sample_t           w_mult_left;
    sample_t           w_mult_right;

    // ------------------------------------------------------------------
    // Level detection (either channel opens, both must be quiet to close)
    // ------------------------------------------------------------------
    assign w_mag_left  = abs_sat(inleft);
    assign w_mag_right = abs_sat(inright);
    assign w_hot       = (w_mag_left >= THRESHOLD) || (w_mag_right >= THRESHOLD);
    assign w_quiet     = (w_mag_left < CLOSE_THR) && (w_mag_right < CLOSE_THR);

    // ------------------------------------------------------------------
    // Gain ramps, saturating at unity and at the floor
    // ------------------------------------------------------------------
    assign w_sum_up  = {1'b0, r_gain} + ATK_STEP;
    assign w_gain_up = (w_sum_up > UNITY) ? UNITY : w_sum_up;
    assign w_gain_dn = ({1'b0, r_gain} >= (FLOOR + REL_STEP)) ?
                       ({1'b0, r_gain} - REL_STEP) : FLOOR;

    // ------------------------------------------------------------------
    // Gain application uses the gain from before this sample's update
    // ------------------------------------------------------------------
    audio_gain_apply u_gain_left (
        .i_sample (sample_t'(inleft)),
        .i_gain   (r_gain),
        .o_sample (w_mult_left)
    );

    audio_gain_apply u_gain_right (
        .i_sample (sample_t'(inright)),
        .i_gain   (r_gain),
        .o_sample (w_mult_right)
    );

    // ------------------------------------------------------------------
    // Gate state machine: next state, gain and hold counter
    // ------------------------------------------------------------------
    always_comb begin
        w_state_d    = r_state;
        w_gain_d     = r_gain;
        w_hold_cnt_d = r_hold_cnt;

        if (in_valid) begin
            unique case (r_state)
                CLOSED: begin
                    w_gain_d = FLOOR[GAIN_W-1:0];
                    // The opening sample already takes the first attack step.
                    if (w_hot) begin
                        w_gain_d  = w_gain_up[GAIN_W-1:0];
                        w_state_d = (w_gain_up == UNITY) ? OPEN : ATTACK;
                    end
                end
                ATTACK: begin
                    w_gain_d = w_gain_up[GAIN_W-1:0];
                    if (w_quiet && (w_gain_up != UNITY)) begin
                        w_state_d = RELEASE;
                    end else if (w_gain_up == UNITY) begin
                        w_state_d = OPEN;
                    end
                end
                OPEN: begin
                    w_gain_d = GAIN_UNITY;
                    if (w_quiet) begin
                        w_state_d    = HOLD;
                        w_hold_cnt_d = HOLD_INIT;
                    end
                end
                HOLD: begin
                    w_gain_d = GAIN_UNITY;
                    if (w_hot) begin
                        w_state_d    = OPEN;
                        w_hold_cnt_d = '0;
                    end else if (w_quiet) begin
                        if (r_hold_cnt == '0) begin
                            w_state_d = RELEASE;
                        end else begin
                            w_hold_cnt_d = r_hold_cnt - 16'd1;
                        end
                    end
                end
                RELEASE: begin
                    // A dead-band sample keeps ramping down; only hot reverses.
                    if (w_hot) begin
                        w_state_d = ATTACK;
                    end else begin
                        w_gain_d = w_gain_dn[GAIN_W-1:0];
                        if (w_gain_dn == FLOOR) begin
                            w_state_d = CLOSED;
                        end
                    end
                end
                default: begin
                    w_state_d    = CLOSED;
                    w_gain_d     = FLOOR[GAIN_W-1:0];
                    w_hold_cnt_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= CLOSED;
            r_gain      <= FLOOR[GAIN_W-1:0];
            r_hold_cnt  <= '0;
            r_out_valid <= 1'b0;
            r_outleft   <= '0;
            r_outright  <= '0;
        end else begin
            r_state     <= w_state_d;
            r_gain      <= w_gain_d;
            r_hold_cnt  <= w_hold_cnt_d;
            r_out_valid <= in_valid;
            if (in_valid) begin
                r_outleft  <= w_mult_left;
                r_outright <= w_mult_right;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign outleft   = r_outleft;
    assign outright  = r_outright;
    assign gain      = r_gain;
    assign gate_open = (r_state != CLOSED);

endmodule

// File: tb/tb_noise_gate.sv
module tb_noise_gate;

    localparam logic [31:0] THR   = 32'h0100_0000;
    localparam logic [31:0] HYST  = 32'h0080_0000;
    localparam int          HOLDN = 4;
    localparam int          ATK   = 32;
    localparam int          REL   = 64;
    localparam int          FLOOR = 0;
`ifdef NOISE_GATE_HYST_EN
    localparam longint CLOSE = longint'(THR) - longint'(HYST);
`else
    localparam longint CLOSE = longint'(THR);
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [31:0] inleft;
    logic [31:0] inright;
    logic        out_valid;
    logic [31:0] outleft;
    logic [31:0] outright;
    logic [8:0]  gain;
    logic        gate_open;

    int total = 0;
    int bad   = 0;

    noise_gate #(
        .THRESHOLD    (THR),
        .HOLD_SAMPLES (HOLDN),
        .ATTACK_STEP  (ATK),
        .RELEASE_STEP (REL),
        .GAIN_FLOOR   (FLOOR),
        .HYSTERESIS   (HYST)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .inleft    (inleft),
        .inright   (inright),
        .out_valid (out_valid),
        .outleft   (outleft),
        .outright  (outright),
        .gain      (gain),
        .gate_open (gate_open)
    );

    always #5 clock = ~clock;

    // Behavioural model: gate phase, gain as an integer, hold countdown.
    typedef enum {M_CLOSED, M_ATTACK, M_OPEN, M_HOLD, M_RELEASE} m_phase_t;
    m_phase_t m_ph;
    int       m_gain;
    int       m_cnt;

    logic [31:0] e_left;
    logic [31:0] e_right;
    logic [8:0]  e_gain;
    bit          e_open;

    function automatic longint magn(input logic [31:0] x);
        longint v;
        v = longint'($signed(x));
        if (v < 0) v = -v;
        if (v > 64'sh7FFF_FFFF) v = 64'sh7FFF_FFFF;
        return v;
    endfunction

    function automatic logic [31:0] scale(input logic [31:0] x, input int g);
        longint p;
        p = longint'($signed(x)) * longint'(g);
        p = p >>> 8;
        return p[31:0];
    endfunction

    task automatic model_reset();
        m_ph   = M_CLOSED;
        m_gain = FLOOR;
        m_cnt  = 0;
        e_left = 0; e_right = 0; e_gain = 9'(FLOOR); e_open = 0;
    endtask

    // Drive one valid sample, then advance the model.
    task automatic step(input logic [31:0] l, input logic [31:0] r);
        bit hot, quiet;
        e_left  = scale(l, m_gain);
        e_right = scale(r, m_gain);
        inleft = l; inright = r; in_valid = 1'b1;
        @(posedge clock); #1;
        in_valid = 1'b0;
        hot   = (magn(l) >= longint'(THR)) || (magn(r) >= longint'(THR));
        quiet = (magn(l) < CLOSE) && (magn(r) < CLOSE);
        case (m_ph)
            M_CLOSED: begin
                m_gain = FLOOR;
                if (hot) begin
                    m_gain = (FLOOR + ATK > 256) ? 256 : FLOOR + ATK;
                    m_ph   = (m_gain == 256) ? M_OPEN : M_ATTACK;
                end
            end
            M_ATTACK: begin
                m_gain = (m_gain + ATK > 256) ? 256 : m_gain + ATK;
                if (quiet && m_gain < 256) m_ph = M_RELEASE;
                else if (m_gain == 256) m_ph = M_OPEN;
            end
            M_OPEN: if (quiet) begin m_ph = M_HOLD; m_cnt = HOLDN - 1; end
            M_HOLD: begin
                if (hot) begin m_ph = M_OPEN; m_cnt = 0; end
                else if (quiet) begin
                    if (m_cnt == 0) m_ph = M_RELEASE;
                    else m_cnt--;
                end
            end
            default: begin
                if (hot) m_ph = M_ATTACK;
                else begin
                    m_gain = (m_gain - REL < FLOOR) ? FLOOR : m_gain - REL;
                    if (m_gain == FLOOR) m_ph = M_CLOSED;
                end
            end
        endcase
        e_gain = 9'(m_gain);
        e_open = (m_ph != M_CLOSED);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #2;
        reset = 1'b0;
        @(posedge clock); #1;
        model_reset();
    endtask

    task automatic test_reset();
        // Power-on reset state
        total++;
        if (out_valid !== 1'b0 || outleft !== 32'd0 || outright !== 32'd0 ||
            gain !== 9'd0 || gate_open !== 1'b0) begin
            bad++;
            $display("FAIL reset_por got v=%b l=%h r=%h g=%0d o=%b want 0/0/0/0/0",
                     out_valid, outleft, outright, gain, gate_open);
        end
        reset = 1'b0;
        @(posedge clock); #1;
        model_reset();
        // Reset asserted mid-ATTACK, checked before any further clock edge
        for (int k = 0; k < 3; k++) step(32'h0200_0000, 32'd0);
        reset = 1'b1;
        #1;
        total++;
        if (out_valid !== 1'b0 || outleft !== 32'd0 || outright !== 32'd0 ||
            gain !== 9'd0 || gate_open !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid got v=%b l=%h r=%h g=%0d o=%b want 0/0/0/0/0",
                     out_valid, outleft, outright, gain, gate_open);
        end
        #1;
        reset = 1'b0;
        @(posedge clock); #1;
        model_reset();
    endtask

    task automatic test_attack();
        logic [31:0] want;
        int          wg;
        do_reset();
        for (int k = 1; k <= 10; k++) begin
            step(32'h0200_0000, 32'd0);
            want = (k <= 9) ? 32'h0040_0000 * (k - 1) : 32'h0200_0000;
            wg   = (32 * k > 256) ? 256 : 32 * k;
            total++;
            if (out_valid !== 1'b1 || outleft !== want || outright !== 32'd0 ||
                gain !== 9'(wg) || gate_open !== 1'b1 || outleft !== e_left) begin
                bad++;
                $display("FAIL attack[%0d] got v=%b l=%h r=%h g=%0d o=%b want l=%h r=0 g=%0d o=1",
                         k, out_valid, outleft, outright, gain, gate_open, want, wg);
            end
        end
    endtask

    task automatic test_hold_release();
        int          gl [10] = '{256, 256, 256, 256, 256, 192, 128, 64, 0, 0};
        logic [31:0] ol [10] = '{32'h10, 32'h10, 32'h10, 32'h10, 32'h10, 32'h10,
                                 32'hC, 32'h8, 32'h4, 32'h0};
        // Continues from the OPEN state left by test_attack
        for (int k = 0; k < 10; k++) begin
            step(32'h0000_0010, 32'h0000_0010);
            total++;
            if (outleft !== ol[k] || outright !== ol[k] || gain !== 9'(gl[k]) ||
                gate_open !== (k < 8) || gain !== e_gain || gate_open !== e_open) begin
                bad++;
                $display("FAIL hold_release[%0d] got l=%h r=%h g=%0d o=%b want l=%h g=%0d o=%b",
                         k, outleft, outright, gain, gate_open, ol[k], gl[k], k < 8);
            end
        end
    endtask

    task automatic test_retrigger();
        do_reset();
        for (int k = 0; k < 8; k++) step(32'h0200_0000, 32'd0);
        step(32'h10, 32'h10);
        step(32'h10, 32'h10);
        step(32'h10, 32'hFE00_0000);
        total++;
        if (gain !== 9'd256 || gate_open !== 1'b1 || outright !== 32'hFE00_0000) begin
            bad++;
            $display("FAIL retrigger_hit got g=%0d o=%b r=%h want 256/1/fe000000",
                     gain, gate_open, outright);
        end
        // Full hold restarts: 5 quiet samples keep unity, the 6th ramps down
        for (int k = 1; k <= 6; k++) begin
            step(32'h10, 32'h10);
            total++;
            if (gain !== ((k <= 5) ? 9'd256 : 9'd192) || gain !== e_gain) begin
                bad++;
                $display("FAIL retrigger_hold[%0d] got g=%0d want %0d",
                         k, gain, (k <= 5) ? 256 : 192);
            end
        end
    endtask

    task automatic test_edge();
        logic [31:0] hl, hr;
        logic [8:0]  hg;
        do_reset();
        step(32'h8000_0000, 32'd0);
        total++;
        if (outleft !== 32'd0 || gain !== 9'd32 || gate_open !== 1'b1) begin
            bad++;
            $display("FAIL edge_min_open got l=%h g=%0d o=%b want 0/32/1", outleft, gain, gate_open);
        end
        step(32'h8000_0000, 32'h7FFF_FFFF);
        total++;
        if (outleft !== 32'hF000_0000 || outright !== e_right || gain !== 9'd64) begin
            bad++;
            $display("FAIL edge_min_scale got l=%h r=%h g=%0d want f0000000/%h/64",
                     outleft, outright, gain, e_right);
        end
        hl = outleft; hr = outright; hg = gain;
        for (int k = 0; k < 3; k++) begin
            inleft = $urandom; inright = $urandom;
            @(posedge clock); #1;
            total++;
            if (out_valid !== 1'b0 || outleft !== hl || outright !== hr || gain !== hg) begin
                bad++;
                $display("FAIL edge_gap[%0d] got v=%b l=%h r=%h g=%0d want 0/%h/%h/%0d",
                         k, out_valid, outleft, outright, gain, hl, hr, hg);
            end
        end
        step(32'h0000_0100, 32'hFFFF_FF00);
        total++;
        if (outleft !== e_left || outright !== e_right || gain !== e_gain || out_valid !== 1'b1) begin
            bad++;
            $display("FAIL edge_resume got l=%h r=%h g=%0d want %h/%h/%0d",
                     outleft, outright, gain, e_left, e_right, e_gain);
        end
    endtask

    task automatic test_hysteresis();
        do_reset();
        for (int k = 0; k < 8; k++) step(32'h0200_0000, 32'd0);
        for (int k = 0; k < 7; k++) step(32'h00C0_0000, 32'd0);
`ifdef NOISE_GATE_HYST_EN
        total++;
        if (gain !== 9'd256) begin
            bad++;
            $display("FAIL hyst_band got g=%0d want 256", gain);
        end
`else
        total++;
        if (gain !== 9'd128) begin
            bad++;
            $display("FAIL hyst_band got g=%0d want 128", gain);
        end
`endif
        for (int k = 0; k < 8; k++) begin
            step(32'h0070_0000, 32'h0070_0000);
            total++;
            if (gain !== e_gain || gate_open !== e_open || outleft !== e_left) begin
                bad++;
                $display("FAIL hyst_close[%0d] got g=%0d o=%b l=%h want %0d/%b/%h",
                         k, gain, gate_open, outleft, e_gain, e_open, e_left);
            end
        end
    endtask

    task automatic test_random();
        int          cls, run, gap;
        logic [31:0] l, r;
        do_reset();
        for (int n = 0; n < 120; n++) begin
            cls = $urandom_range(9);
            run = $urandom_range(12, 1);
            for (int k = 0; k < run; k++) begin
                for (int c = 0; c < 2; c++) begin
                    if (cls <= 2)      l = $urandom_range(32'h7FFF_FFFF, 32'h0100_0000);
                    else if (cls == 3) l = ($urandom_range(1) != 0) ? 32'h8000_0000 : 32'h00FF_FFFF;
                    else if (cls <= 5) l = $urandom_range(32'h00FF_FFFF, 32'h0070_0000);
                    else               l = $urandom_range(32'h0001_0000);
                    if ($urandom_range(1) != 0) l = -l;
                    if (c == 0) r = l;
                end
                if ($urandom_range(2) == 0) r = 32'd0;
                step(l, r);
                total++;
                if (out_valid !== 1'b1 || outleft !== e_left || outright !== e_right ||
                    gain !== e_gain || gate_open !== e_open) begin
                    bad++;
                    $display("FAIL random[%0d.%0d] got v=%b l=%h r=%h g=%0d o=%b want 1/%h/%h/%0d/%b",
                             n, k, out_valid, outleft, outright, gain, gate_open,
                             e_left, e_right, e_gain, e_open);
                end
                gap = ($urandom_range(5) == 0) ? $urandom_range(2, 1) : 0;
                for (int g = 0; g < gap; g++) begin
                    inleft = $urandom; inright = $urandom;
                    @(posedge clock); #1;
                    total++;
                    if (out_valid !== 1'b0 || outleft !== e_left || gain !== e_gain) begin
                        bad++;
                        $display("FAIL random_gap[%0d] got v=%b l=%h g=%0d want 0/%h/%0d",
                                 n, out_valid, outleft, gain, e_left, e_gain);
                    end
                end
            end
        end
    endtask

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        inleft   = 32'd0;
        inright  = 32'd0;
        #12;
        test_reset();
        test_attack();
        test_hold_release();
        test_retrigger();
        test_edge();
        test_hysteresis();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
